// File: rtl/jtag_debug_pkg.sv
// Shared definitions for the sysclk-side JTAG debug command consumer:
// IR codes, command-word bit positions, sequencer states and the strobe decode.
package jtag_debug_pkg;

    localparam int JDO_W = 38;

    localparam logic [1:0] IR_OCIMEM = 2'b00;
    localparam logic [1:0] IR_STATUS = 2'b01;
    localparam logic [1:0] IR_BREAK  = 2'b10;
    localparam logic [1:0] IR_TRACE  = 2'b11;

    localparam int JDO_ACTION  = 35;
    localparam int JDO_OCI_SEL = 34;
    localparam int JDO_SUB_HI  = 37;
    localparam int JDO_SUB_LO  = 36;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPT     = 2'd1,
        DECODE   = 2'd2,
        WAIT_ACK = 2'd3
    } cmd_state_t;

    typedef struct packed {
        logic ta_ocimem_a;
        logic ta_ocimem_b;
        logic tn_ocimem_a;
        logic ta_break_a;
        logic ta_break_b;
        logic ta_break_c;
        logic tn_break_a;
        logic tn_break_b;
        logic tn_break_c;
        logic ta_tracectrl;
    } strobe_t;

    // At most one field of the result is set; status reads produce none.
    function automatic strobe_t decode_cmd(input logic [1:0] ir, input logic [JDO_W-1:0] word);
        strobe_t    s;
        logic       act;
        logic [1:0] sub;
        s   = '0;
        act = word[JDO_ACTION];
        sub = word[JDO_SUB_HI:JDO_SUB_LO];
        case (ir)
            IR_OCIMEM: begin
                if (act) begin
                    if (word[JDO_OCI_SEL]) s.ta_ocimem_b = 1'b1;
                    else                   s.ta_ocimem_a = 1'b1;
                end else begin
                    s.tn_ocimem_a = 1'b1;
                end
            end
            IR_BREAK: begin
                if (sub[1]) begin
                    if (act) s.ta_break_c = 1'b1;
                    else     s.tn_break_c = 1'b1;
                end else if (sub[0]) begin
                    if (act) s.ta_break_b = 1'b1;
                    else     s.tn_break_b = 1'b1;
                end else begin
                    if (act) s.ta_break_a = 1'b1;
                    else     s.tn_break_a = 1'b1;
                end
            end
            IR_TRACE: s.ta_tracectrl = act;
            default:  s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/jtag_strobe_sync.sv
// Brings a TCK-domain update level into clk and flags its rising edge for
// exactly one clk cycle.
module jtag_strobe_sync #(
    parameter int SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  edge_q;

    // Synchronizer chain followed by the edge-detect history flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
            edge_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~edge_q;

endmodule

// File: rtl/jtag_debug_cmd_sync.sv
// Sysclk-side consumer of the debug-slave TCK shift register: captures each
// update-DR command into jdo and issues one decoded action strobe, with an
// ack/timeout handshake for OCI memory actions.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a synchronized update-DR edge
// CAPT     | sample sr into jdo, count the command
// DECODE   | issue the decoded strobe (visible the following cycle)
// WAIT_ACK | OCI memory action outstanding, waiting for cmd_ack or timeout
module jtag_debug_cmd_sync
    import jtag_debug_pkg::*;
#(
    parameter int SYNC_DEPTH  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JDO_W-1:0] sr,
    input  logic [1:0]       ir_in,
    input  logic             vs_udr,
    input  logic             vs_uir,
    input  logic             cmd_ack,
    input  logic             err_clr,
    output logic [JDO_W-1:0] jdo,
    output logic             take_action_ocimem_a,
    output logic             take_action_ocimem_b,
    output logic             take_no_action_ocimem_a,
    output logic             take_action_break_a,
    output logic             take_action_break_b,
    output logic             take_action_break_c,
    output logic             take_no_action_break_a,
    output logic             take_no_action_break_b,
    output logic             take_no_action_break_c,
    output logic             take_action_tracectrl,
    output logic             cmd_pending,
    output logic             overrun_err,
    output logic             timeout_err,
    output logic [7:0]       cmd_count
);

    localparam logic [7:0] ACK_LOAD = 8'(ACK_TIMEOUT);

    logic       udr_rise;
    logic       uir_rise;
    logic [1:0] ir_q;
    cmd_state_t state;
    logic [7:0] ack_cnt;
    strobe_t    strobe_d;
    strobe_t    strobe_q;
    logic       oci_action;
    logic       ack_expired;
    logic       overrun_set;
    logic       timeout_set;

    jtag_strobe_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_udr_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_udr),
        .rise     (udr_rise)
    );

    jtag_strobe_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_uir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    // Virtual IR follows every update-IR edge regardless of sequencer state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= 2'b00;
        end else if (uir_rise) begin
            ir_q <= ir_in;
        end
    end

    assign strobe_d    = decode_cmd(ir_q, jdo);
    assign oci_action  = strobe_d.ta_ocimem_a | strobe_d.ta_ocimem_b;
    // ack_cnt is loaded with ACK_TIMEOUT on entry, so reaching 1 means the
    // full wait window has elapsed without an ack.
    assign ack_expired = (ack_cnt == 8'd1);

    // Command sequencer with registered strobes, capture word and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            jdo         <= '0;
            cmd_count   <= 8'd0;
            strobe_q    <= '0;
            cmd_pending <= 1'b0;
            ack_cnt     <= 8'd0;
        end else begin
            strobe_q <= '0;
            case (state)
                IDLE: begin
                    if (udr_rise) state <= CAPT;
                end
                CAPT: begin
                    jdo       <= sr;
                    cmd_count <= cmd_count + 8'd1;
                    state     <= DECODE;
                end
                DECODE: begin
                    strobe_q <= strobe_d;
                    if (oci_action) begin
                        cmd_pending <= 1'b1;
                        ack_cnt     <= ACK_LOAD;
                        state       <= WAIT_ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_ACK: begin
                    if (cmd_ack || ack_expired) begin
                        cmd_pending <= 1'b0;
                        ack_cnt     <= 8'd0;
                        state       <= IDLE;
                    end else begin
                        ack_cnt <= ack_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A command arriving while one is still in flight is dropped and flagged
    assign overrun_set = udr_rise && (state != IDLE);
    assign timeout_set = (state == WAIT_ACK) && !cmd_ack && ack_expired;

    // Sticky error flags; a new error in the same cycle as err_clr wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
            timeout_err <= timeout_set | (timeout_err & ~err_clr);
        end
    end

    assign take_action_ocimem_a    = strobe_q.ta_ocimem_a;
    assign take_action_ocimem_b    = strobe_q.ta_ocimem_b;
    assign take_no_action_ocimem_a = strobe_q.tn_ocimem_a;
    assign take_action_break_a     = strobe_q.ta_break_a;
    assign take_action_break_b     = strobe_q.ta_break_b;
    assign take_action_break_c     = strobe_q.ta_break_c;
    assign take_no_action_break_a  = strobe_q.tn_break_a;
    assign take_no_action_break_b  = strobe_q.tn_break_b;
    assign take_no_action_break_c  = strobe_q.tn_break_c;
    assign take_action_tracectrl   = strobe_q.ta_tracectrl;

endmodule

// File: tb/tb_jtag_debug_cmd_sync.sv
// Bench for jtag_debug_cmd_sync: timestamp-based command model checked every
// cycle, plus literal checks at the points the scenarios care about.
module tb_jtag_debug_cmd_sync;

    localparam int D = 2;
    localparam int T = 16;
    localparam int BIG = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] sr = '0;
    logic [1:0]  ir_in = 2'b00;
    logic        vs_udr = 1'b0;
    logic        vs_uir = 1'b0;
    logic        cmd_ack = 1'b0;
    logic        err_clr = 1'b0;
    logic [37:0] jdo;
    logic        ta_oci_a, ta_oci_b, tn_oci_a;
    logic        ta_brk_a, ta_brk_b, ta_brk_c, tn_brk_a, tn_brk_b, tn_brk_c;
    logic        ta_trace;
    logic        cmd_pending, overrun_err, timeout_err;
    logic [7:0]  cmd_count;
    logic [9:0]  dut_strobes;

    always #5 clk = ~clk;

    jtag_debug_cmd_sync #(.SYNC_DEPTH(D), .ACK_TIMEOUT(T)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .sr                      (sr),
        .ir_in                   (ir_in),
        .vs_udr                  (vs_udr),
        .vs_uir                  (vs_uir),
        .cmd_ack                 (cmd_ack),
        .err_clr                 (err_clr),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_oci_a),
        .take_action_ocimem_b    (ta_oci_b),
        .take_no_action_ocimem_a (tn_oci_a),
        .take_action_break_a     (ta_brk_a),
        .take_action_break_b     (ta_brk_b),
        .take_action_break_c     (ta_brk_c),
        .take_no_action_break_a  (tn_brk_a),
        .take_no_action_break_b  (tn_brk_b),
        .take_no_action_break_c  (tn_brk_c),
        .take_action_tracectrl   (ta_trace),
        .cmd_pending             (cmd_pending),
        .overrun_err             (overrun_err),
        .timeout_err             (timeout_err),
        .cmd_count               (cmd_count)
    );

    // [9] ta_oci_a [8] ta_oci_b [7] tn_oci_a [6:4] ta_brk_a..c [3:1] tn_brk_a..c [0] trace
    assign dut_strobes = {ta_oci_a, ta_oci_b, tn_oci_a, ta_brk_a, ta_brk_b, ta_brk_c,
                          tn_brk_a, tn_brk_b, tn_brk_c, ta_trace};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [9:0] exp_strobe(input logic [1:0] ir, input logic [37:0] w);
        logic [9:0] v;
        int unit;
        v = 10'h000;
        unit = w[37] ? 2 : (w[36] ? 1 : 0);
        if (ir == 2'b00)                v = !w[35] ? 10'h080 : (w[34] ? 10'h100 : 10'h200);
        else if (ir == 2'b10)           v = w[35] ? (10'h040 >> unit) : (10'h008 >> unit);
        else if (ir == 2'b11 && w[35])  v = 10'h001;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          m_edge = 0;
    int          m_free, m_cap_at, m_dec_at, m_wait_start;
    logic [7:0]  udr_hist, uir_hist;
    logic [1:0]  m_ir;
    logic [37:0] m_jdo;
    logic [7:0]  m_cnt;
    logic [9:0]  m_strobe;
    logic        m_pend, m_ovr, m_tmo;
    logic        udr_seen, uir_seen, ovr_evt, tmo_evt;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_hist = '0; uir_hist = '0;
            m_free = 0; m_cap_at = -1; m_dec_at = -1; m_wait_start = 0;
            m_ir = 2'b00; m_jdo = '0; m_cnt = 8'd0; m_strobe = '0;
            m_pend = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0;
        end else begin
            m_edge = m_edge + 1;
            // a TCK level first sampled at edge k is acted on at edge k+D
            udr_seen = udr_hist[D-1] & ~udr_hist[D];
            uir_seen = uir_hist[D-1] & ~uir_hist[D];
            udr_hist = {udr_hist[6:0], vs_udr};
            uir_hist = {uir_hist[6:0], vs_uir};
            m_strobe = '0;
            ovr_evt = 1'b0;
            tmo_evt = 1'b0;
            if (udr_seen) begin
                if (m_edge >= m_free) begin
                    m_cap_at = m_edge + 1;
                    m_free   = m_edge + 3;
                end else begin
                    ovr_evt = 1'b1;
                end
            end
            if (m_edge == m_cap_at) begin
                m_jdo    = sr;
                m_cnt    = m_cnt + 8'd1;
                m_dec_at = m_edge + 1;
            end
            if (m_edge == m_dec_at) begin
                m_strobe = exp_strobe(m_ir, m_jdo);
                if (m_strobe[9] || m_strobe[8]) begin
                    m_pend = 1'b1;
                    m_wait_start = m_edge;
                    m_free = BIG;
                end
            end else if (m_pend && m_edge > m_wait_start) begin
                if (cmd_ack) begin
                    m_pend = 1'b0;
                    m_free = m_edge + 1;
                end else if (m_edge - m_wait_start == T) begin
                    m_pend = 1'b0;
                    tmo_evt = 1'b1;
                    m_free = m_edge + 1;
                end
            end
            if (uir_seen) m_ir = ir_in;
            if (err_clr) begin m_ovr = 1'b0; m_tmo = 1'b0; end
            if (ovr_evt) m_ovr = 1'b1;
            if (tmo_evt) m_tmo = 1'b1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (reset_n) begin
            check("jdo",         64'(jdo),         64'(m_jdo));
            check("strobes",     64'(dut_strobes), 64'(m_strobe));
            check("cmd_pending", 64'(cmd_pending), 64'(m_pend));
            check("overrun_err", 64'(overrun_err), 64'(m_ovr));
            check("timeout_err", 64'(timeout_err), 64'(m_tmo));
            check("cmd_count",   64'(cmd_count),   64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic goto_edge(input int e);
        while (cyc < e) begin @(posedge clk); #1; end
    endtask

    task automatic sample_at(input int e);
        goto_edge(e);
        @(negedge clk);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_ir(input logic [1:0] ir);
        @(posedge clk); #1;
        ir_in = ir;
        vs_uir = 1'b1;
        wait_edges(2);
        vs_uir = 1'b0;
        wait_edges(6);
    endtask

    task automatic pulse_udr(input logic [37:0] val, output int e0);
        @(posedge clk); #1;
        sr = val;
        vs_udr = 1'b1;
        e0 = cyc;
        wait_edges(2);
        vs_udr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk); #1;
        err_clr = 1'b1;
        wait_edges(1);
        err_clr = 1'b0;
    endtask

    localparam logic [37:0] SR1 = {3'b011, 35'h0_1234_5678};
    localparam logic [37:0] SR2 = {4'b0010, 34'h0_ABCD_1234};
    localparam logic [37:0] SR3 = {4'b1111, 34'h1_0F0F_0F0F};
    localparam logic [37:0] SR4 = {3'b101, 35'h2_4444_4444};
    localparam logic [37:0] SR5 = {4'b0111, 34'h1_5555_5555};
    localparam logic [37:0] SR6 = {3'b100, 35'h7_FFFF_0000};
    localparam logic [37:0] SR7 = {3'b001, 35'h0_0000_0001};
    localparam logic [37:0] SR8 = {3'b000, 35'h3_3333_3333};

    logic [1:0]  ir_tab  [7];
    logic [37:0] sr_tab  [7];
    logic [9:0]  exp_tab [7];

    initial begin
        int e0, e1, e2, s;
        ir_tab  = '{2'b11, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        sr_tab  = '{{3'b001, 35'h0_0000_00A5}, {3'b100, 35'h1_0000_0000},
                    {4'b1101, 34'h0_0000_1111}, {3'b010, 35'h0_2222_2222},
                    {3'b110, 35'h0_0000_0003}, {3'b001, 35'h5_0000_0000},
                    {3'b111, 35'h7_7777_7777}};
        exp_tab = '{10'h001, 10'h000, 10'h080, 10'h004, 10'h002, 10'h040, 10'h000};

        wait_edges(3);
        @(negedge clk);
        check("reset_jdo",     64'(jdo),         64'h0);
        check("reset_strobes", 64'(dut_strobes), 64'h0);
        check("reset_count",   64'(cmd_count),   64'h0);
        reset_n = 1'b1;
        wait_edges(3);

        // break_b action: latency, width, capture
        set_ir(2'b10);
        pulse_udr(SR1, e0);
        sample_at(e0 + D + 2);
        check("brk_b_early", 64'(dut_strobes), 64'h000);
        sample_at(e0 + D + 3);
        check("brk_b_pulse", 64'(dut_strobes), 64'h020);
        check("brk_b_jdo",   64'(jdo),         64'(SR1));
        check("brk_b_count", 64'(cmd_count),   64'd1);
        sample_at(e0 + D + 4);
        check("brk_b_late",  64'(dut_strobes), 64'h000);

        // ocimem_a action acknowledged after a few cycles
        set_ir(2'b00);
        pulse_udr(SR2, e0);
        s = e0 + D + 3;
        sample_at(s);
        check("oci_a_pulse",   64'(dut_strobes), 64'h200);
        check("oci_a_pending", 64'(cmd_pending), 64'd1);
        goto_edge(s + 5);
        cmd_ack = 1'b1;
        @(negedge clk);
        check("oci_a_still_pending", 64'(cmd_pending), 64'd1);
        goto_edge(s + 6);
        cmd_ack = 1'b0;
        @(negedge clk);
        check("oci_a_acked", 64'(cmd_pending), 64'd0);
        check("oci_a_no_err", 64'({overrun_err, timeout_err}), 64'd0);

        // ocimem_b action with no ack times out, next break decodes
        pulse_udr(SR3, e0);
        s = e0 + D + 3;
        sample_at(s);
        check("oci_b_pulse", 64'(dut_strobes), 64'h100);
        sample_at(s + T - 1);
        check("tmo_pending_last", 64'(cmd_pending), 64'd1);
        check("tmo_not_yet",      64'(timeout_err), 64'd0);
        sample_at(s + T);
        check("tmo_pending_clr",  64'(cmd_pending), 64'd0);
        check("tmo_set",          64'(timeout_err), 64'd1);
        set_ir(2'b10);
        pulse_udr(SR4, e0);
        sample_at(e0 + D + 3);
        check("brk_c_after_tmo", 64'(dut_strobes), 64'h010);
        check("tmo_sticky",      64'(timeout_err), 64'd1);
        pulse_err_clr();
        @(negedge clk);
        check("tmo_cleared", 64'(timeout_err), 64'd0);

        // overrun while waiting for ack, set beats clear
        set_ir(2'b00);
        pulse_udr(SR5, e0);
        s = e0 + D + 3;
        goto_edge(s + 2);
        pulse_udr(SR6, e1);
        sample_at(e1 + D + 2);
        check("ovr_set",   64'(overrun_err), 64'd1);
        check("ovr_jdo",   64'(jdo),         64'(SR5));
        check("ovr_count", 64'(cmd_count),   64'd5);
        pulse_udr(SR6, e2);
        goto_edge(e2 + D);
        err_clr = 1'b1;
        goto_edge(e2 + D + 1);
        err_clr = 1'b0;
        @(negedge clk);
        check("ovr_set_wins", 64'(overrun_err), 64'd1);
        wait_edges(2);
        cmd_ack = 1'b1;
        wait_edges(1);
        cmd_ack = 1'b0;
        pulse_err_clr();
        @(negedge clk);
        check("ovr_cleared", 64'(overrun_err), 64'd0);
        wait_edges(4);

        // reset in DECODE drops the in-flight break command
        set_ir(2'b10);
        pulse_udr(SR7, e0);
        goto_edge(e0 + D + 2);
        reset_n = 1'b0;
        #1;
        check("rst_jdo",     64'(jdo),         64'h0);
        check("rst_strobes", 64'(dut_strobes), 64'h0);
        check("rst_count",   64'(cmd_count),   64'h0);
        check("rst_flags",   64'({cmd_pending, overrun_err, timeout_err}), 64'h0);
        wait_edges(3);
        reset_n = 1'b1;
        wait_edges(10);

        // 256 status reads: no strobes, counter wraps
        set_ir(2'b01);
        for (int i = 0; i < 256; i++) begin
            pulse_udr({6'(i), 32'hC0DE_0000 ^ 32'(i * 7)}, e0);
            wait_edges(6);
            if (i == 254) begin
                @(negedge clk);
                check("status_count_255", 64'(cmd_count), 64'd255);
            end
        end
        @(negedge clk);
        check("status_count_wrap", 64'(cmd_count), 64'd0);

        set_ir(2'b10);
        pulse_udr(SR8, e0);
        sample_at(e0 + D + 3);
        check("post_rst_brk_a_no", 64'(dut_strobes), 64'h008);
        check("post_rst_count",    64'(cmd_count),   64'd1);

        // remaining decode table entries
        for (int k = 0; k < 7; k++) begin
            set_ir(ir_tab[k]);
            pulse_udr(sr_tab[k], e0);
            sample_at(e0 + D + 3);
            check($sformatf("decode_%0d", k), 64'(dut_strobes), 64'(exp_tab[k]));
            wait_edges(4);
        end

        wait_edges(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
